// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between ALU (A) and load (B) writeback, tracks pending writes
module regfile_wb_arbiter #(
    parameter int ARB_MODE     = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        regwrite,
    output logic [4:0]  rd,
    output logic [31:0] write_data,
    output logic [31:0] busy
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic        last_b_q, last_b_d;
    logic [3:0]  starve_q, starve_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] write_data_q, write_data_d;
    logic [31:0] busy_q, busy_d;
    logic        prefer_b, xfer;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data, clr_mask, set_mask;

    // Grant: a lone requester always wins; under contention the arbitration mode picks B or A
    always_comb begin
        prefer_b = (ARB_MODE == 0) ? !last_b_q : (starve_q == LIMIT);
        a_ready  = !reset && a_valid && !(b_valid && prefer_b);
        b_ready  = !reset && b_valid && !(a_valid && !prefer_b);
        xfer     = a_ready || b_ready;
        sel_rd   = b_ready ? b_rd : a_rd;
        sel_data = b_ready ? b_data : a_data;
    end

    // Next state: arbitration history, output stage, and scoreboard where a new issue beats a same-index retire
    always_comb begin
        last_b_d     = xfer ? b_ready : last_b_q;
        starve_d     = (!b_valid || b_ready) ? 4'd0 : ((starve_q == LIMIT) ? LIMIT : starve_q + 4'd1);
        regwrite_d   = xfer && (sel_rd != 5'd0);
        rd_d         = xfer ? sel_rd : rd_q;
        write_data_d = xfer ? sel_data : write_data_q;
        clr_mask     = regwrite_q ? (32'd1 << rd_q) : 32'd0;
        set_mask     = (issue_valid && (issue_rd != 5'd0)) ? (32'd1 << issue_rd) : 32'd0;
        busy_d       = (busy_q & ~clr_mask) | set_mask;
    end

    // State registers; reset leaves B as last grant so A wins the first contention
    always_ff @(posedge clk) begin
        if (reset) begin
            last_b_q     <= 1'b1;
            starve_q     <= 4'd0;
            regwrite_q   <= 1'b0;
            rd_q         <= 5'd0;
            write_data_q <= 32'd0;
            busy_q       <= 32'd0;
        end else begin
            last_b_q     <= last_b_d;
            starve_q     <= starve_d;
            regwrite_q   <= regwrite_d;
            rd_q         <= rd_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
        end
    end

    assign regwrite   = regwrite_q;
    assign rd         = rd_q;
    assign write_data = write_data_q;
    assign busy       = busy_q;
endmodule
